// File: rtl/reg_file_sb_pkg.sv
// Shared definitions for the reg_file_sb register file.
//   - Forward-select codes used by every read port (00 register file with
//     write-through bypass, 01 writeback data, 10 R0 data, 11 reserved).
//   - Default widths and sizes for the top-level parameters.
package reg_file_sb_pkg;

  localparam int DEF_REG_DATA_WIDTH    = 16;
  localparam int DEF_REG_NUM_WIDTH     = 4;
  localparam int DEF_NUM_REG           = 16;
  localparam int DEF_NUM_RD_PORTS      = 2;
  localparam int DEF_REG_FORWARD_WIDTH = 2;

  localparam logic [1:0] REG_FORWARD_REG_FILE = 2'b00;
  localparam logic [1:0] REG_FORWARD_WB       = 2'b01;
  localparam logic [1:0] REG_FORWARD_R0       = 2'b10;
  localparam logic [1:0] REG_FORWARD_RSVD     = 2'b11;

endpackage

// File: rtl/reg_file_sb_rd_port.sv
// reg_rd_port: one combinational read port of reg_file_sb.
//   Selects the operand source from the forward code, applies the
//   write-through bypass for register-file reads, range-checks the register
//   number and qualifies the scoreboard busy bit.
// Ports:
//   i_rn        register number read by this port
//   i_fwd       forward select (register file / WB / R0 / reserved)
//   i_wr/i_wrn/i_wrd   writeback port of the current cycle
//   i_wr0/i_r0d        R0 write port of the current cycle
//   i_rfile     current register array contents
//   i_busy_bits current scoreboard bits, one per register
//   o_rd        operand data
//   o_busy      operand still pending (only for register-file reads)
//   o_ex        this port sees an out-of-range number or reserved code
module reg_rd_port
  import reg_file_sb_pkg::*;
#(
  parameter int REG_DATA_WIDTH    = DEF_REG_DATA_WIDTH,
  parameter int REG_NUM_WIDTH     = DEF_REG_NUM_WIDTH,
  parameter int NUM_REG           = DEF_NUM_REG,
  parameter int REG_FORWARD_WIDTH = DEF_REG_FORWARD_WIDTH
) (
  input  logic [REG_NUM_WIDTH-1:0]     i_rn,
  input  logic [REG_FORWARD_WIDTH-1:0] i_fwd,
  input  logic                         i_wr,
  input  logic [REG_NUM_WIDTH-1:0]     i_wrn,
  input  logic [REG_DATA_WIDTH-1:0]    i_wrd,
  input  logic                         i_wr0,
  input  logic [REG_DATA_WIDTH-1:0]    i_r0d,
  input  logic [REG_DATA_WIDTH-1:0]    i_rfile [NUM_REG],
  input  logic [NUM_REG-1:0]           i_busy_bits,
  output logic [REG_DATA_WIDTH-1:0]    o_rd,
  output logic                         o_busy,
  output logic                         o_ex
);

  localparam logic [REG_NUM_WIDTH:0] NUM_REG_L = (REG_NUM_WIDTH+1)'(NUM_REG);

  logic                      w_rn_ok;
  logic                      w_wrn_ok;
  logic                      w_wb_hit;
  logic                      w_r0_hit;
  logic [REG_DATA_WIDTH-1:0] w_arr;
  logic [REG_DATA_WIDTH-1:0] w_bypass;

  assign w_rn_ok  = ({1'b0, i_rn} < NUM_REG_L);
  assign w_wrn_ok = ({1'b0, i_wrn} < NUM_REG_L);

  // A same-cycle write to the register being read is returned directly, so
  // the one-edge array write latency is invisible to the reader.
  assign w_wb_hit = i_wr && w_wrn_ok && (i_wrn == i_rn);
  assign w_r0_hit = i_wr0 && (i_rn == '0);

  assign w_arr    = w_rn_ok ? i_rfile[i_rn] : '0;
  // R0 port beats the writeback port, matching the write-side priority.
  assign w_bypass = w_r0_hit ? i_r0d : (w_wb_hit ? i_wrd : w_arr);

  // An out-of-range register number poisons the port whatever the forward
  // code: data reads as 0 and the port raises its exception.
  always_comb begin
    o_rd   = '0;
    o_busy = 1'b0;
    o_ex   = ~w_rn_ok;
    if (w_rn_ok) begin
      case (i_fwd)
        REG_FORWARD_WIDTH'(REG_FORWARD_REG_FILE): begin
          o_rd   = w_bypass;
          o_busy = i_busy_bits[i_rn] & ~(w_wb_hit | w_r0_hit);
        end
        REG_FORWARD_WIDTH'(REG_FORWARD_WB): o_rd = i_wrd;
        REG_FORWARD_WIDTH'(REG_FORWARD_R0): o_rd = i_r0d;
        default:                            o_ex = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/reg_file_sb.sv
// reg_file_sb: decode-stage register file with write-through bypass,
// per-register busy scoreboard and sticky exception flag.
// Ports:
//   clk, rst_n         rising-edge clock, asynchronous active-low reset
//   rn, reg_forward    packed per-port register numbers and forward codes
//   rd, busy           packed per-port read data and operand-pending flags
//   wr, wrn, wrd       writeback port
//   wr0, r0d           dedicated R0 write port
//   rd0                R0 view: r0d when wr0, else R0 contents
//   iss, iss_rn        issue: marks iss_rn busy
//   ex_clr             clears ex_sticky when no exception this cycle
//   exception          combinational exception for this cycle
//   ex_sticky          registered OR of past exceptions
module reg_file_sb
  import reg_file_sb_pkg::*;
#(
  parameter int REG_DATA_WIDTH    = DEF_REG_DATA_WIDTH,
  parameter int REG_NUM_WIDTH     = DEF_REG_NUM_WIDTH,
  parameter int NUM_REG           = DEF_NUM_REG,
  parameter int NUM_RD_PORTS      = DEF_NUM_RD_PORTS,
  parameter int REG_FORWARD_WIDTH = DEF_REG_FORWARD_WIDTH
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic [NUM_RD_PORTS*REG_NUM_WIDTH-1:0]     rn,
  input  logic [NUM_RD_PORTS*REG_FORWARD_WIDTH-1:0] reg_forward,
  output logic [NUM_RD_PORTS*REG_DATA_WIDTH-1:0]    rd,
  output logic [NUM_RD_PORTS-1:0]                   busy,
  input  logic                                      wr,
  input  logic [REG_NUM_WIDTH-1:0]                  wrn,
  input  logic [REG_DATA_WIDTH-1:0]                 wrd,
  input  logic                                      wr0,
  input  logic [REG_DATA_WIDTH-1:0]                 r0d,
  output logic [REG_DATA_WIDTH-1:0]                 rd0,
  input  logic                                      iss,
  input  logic [REG_NUM_WIDTH-1:0]                  iss_rn,
  input  logic                                      ex_clr,
  output logic                                      exception,
  output logic                                      ex_sticky
);

  localparam logic [REG_NUM_WIDTH:0] NUM_REG_L = (REG_NUM_WIDTH+1)'(NUM_REG);

  logic [REG_DATA_WIDTH-1:0] r_rfile [NUM_REG];
  logic [NUM_REG-1:0]        r_busy;
  logic                      r_sticky;

  logic                      w_wr_ok;
  logic                      w_iss_ok;
  logic [NUM_REG-1:0]        w_wr_hit;
  logic [NUM_REG-1:0]        w_r0_hit;
  logic [NUM_REG-1:0]        w_iss_hit;
  logic [NUM_RD_PORTS-1:0]   w_port_ex;

  // Out-of-range writes and issues are dropped here; they only raise the
  // exception.
  assign w_wr_ok  = wr  && ({1'b0, wrn}    < NUM_REG_L);
  assign w_iss_ok = iss && ({1'b0, iss_rn} < NUM_REG_L);

  assign w_r0_hit = NUM_REG'(wr0);

  for (genvar g = 0; g < NUM_REG; g++) begin : g_dec
    assign w_wr_hit[g]  = w_wr_ok  && (wrn    == REG_NUM_WIDTH'(g));
    assign w_iss_hit[g] = w_iss_ok && (iss_rn == REG_NUM_WIDTH'(g));
  end

  for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_port
    reg_rd_port #(
      .REG_DATA_WIDTH    (REG_DATA_WIDTH),
      .REG_NUM_WIDTH     (REG_NUM_WIDTH),
      .NUM_REG           (NUM_REG),
      .REG_FORWARD_WIDTH (REG_FORWARD_WIDTH)
    ) u_port (
      .i_rn        (rn[p*REG_NUM_WIDTH +: REG_NUM_WIDTH]),
      .i_fwd       (reg_forward[p*REG_FORWARD_WIDTH +: REG_FORWARD_WIDTH]),
      .i_wr        (wr),
      .i_wrn       (wrn),
      .i_wrd       (wrd),
      .i_wr0       (wr0),
      .i_r0d       (r0d),
      .i_rfile     (r_rfile),
      .i_busy_bits (r_busy),
      .o_rd        (rd[p*REG_DATA_WIDTH +: REG_DATA_WIDTH]),
      .o_busy      (busy[p]),
      .o_ex        (w_port_ex[p])
    );
  end

  assign exception = (|w_port_ex) | (wr & ~w_wr_ok) | (iss & ~w_iss_ok);
  assign rd0       = wr0 ? r0d : r_rfile[0];
  assign ex_sticky = r_sticky;

  // Storage and scoreboard. On an R0 collision the R0 port wins; on a
  // same-edge issue and writeback of one register the issue wins, since the
  // newer producer is still outstanding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REG; i++) r_rfile[i] <= '0;
      r_busy <= '0;
    end else begin
      for (int i = 0; i < NUM_REG; i++) begin
        if (w_r0_hit[i])      r_rfile[i] <= r0d;
        else if (w_wr_hit[i]) r_rfile[i] <= wrd;
      end
      r_busy <= (r_busy & ~(w_wr_hit | w_r0_hit)) | w_iss_hit;
    end
  end

  // Set beats clear: a clear request in an excepting cycle is ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          r_sticky <= 1'b0;
    else if (exception)  r_sticky <= 1'b1;
    else if (ex_clr)     r_sticky <= 1'b0;
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: 4 read ports, 32-bit data, 12 registers behind a
// 4-bit register number (so numbers 12..15 are out of range).
module tb_reg_file_sb;

  localparam int DW = 32;
  localparam int NW = 4;
  localparam int NR = 12;
  localparam int NP = 4;
  localparam int FW = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NP*NW-1:0]  rn;
  logic [NP*FW-1:0]  reg_forward;
  logic [NP*DW-1:0]  rd;
  logic [NP-1:0]     busy;
  logic              wr;
  logic [NW-1:0]     wrn;
  logic [DW-1:0]     wrd;
  logic              wr0;
  logic [DW-1:0]     r0d;
  logic [DW-1:0]     rd0;
  logic              iss;
  logic [NW-1:0]     iss_rn;
  logic              ex_clr;
  logic              exception;
  logic              ex_sticky;

  reg_file_sb #(
    .REG_DATA_WIDTH    (DW),
    .REG_NUM_WIDTH     (NW),
    .NUM_REG           (NR),
    .NUM_RD_PORTS      (NP),
    .REG_FORWARD_WIDTH (FW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rn          (rn),
    .reg_forward (reg_forward),
    .rd          (rd),
    .busy        (busy),
    .wr          (wr),
    .wrn         (wrn),
    .wrd         (wrd),
    .wr0         (wr0),
    .r0d         (r0d),
    .rd0         (rd0),
    .iss         (iss),
    .iss_rn      (iss_rn),
    .ex_clr      (ex_clr),
    .exception   (exception),
    .ex_sticky   (ex_sticky)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [DW-1:0] m_rf   [NR];
  logic          m_busy [NR];
  logic          m_sticky;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic int port_rn(input int p);
    return int'(rn[p*NW +: NW]);
  endfunction

  function automatic int port_fwd(input int p);
    return int'(reg_forward[p*FW +: FW]);
  endfunction

  function automatic logic wr_lands(input int n);
    return wr && (int'(wrn) == n) && (int'(wrn) < NR);
  endfunction

  function automatic logic [DW-1:0] exp_rd(input int p);
    int n = port_rn(p);
    int f = port_fwd(p);
    if (n >= NR) return '0;
    case (f)
      0: begin
        if (n == 0 && wr0) return r0d;
        if (wr_lands(n))   return wrd;
        return m_rf[n];
      end
      1:       return wrd;
      2:       return r0d;
      default: return '0;
    endcase
  endfunction

  function automatic logic exp_busy(input int p);
    int n = port_rn(p);
    if (port_fwd(p) != 0 || n >= NR) return 1'b0;
    if (wr_lands(n) || (n == 0 && wr0)) return 1'b0;
    return m_busy[n];
  endfunction

  function automatic logic exp_exc();
    logic e = 1'b0;
    for (int p = 0; p < NP; p++)
      if (port_rn(p) >= NR || port_fwd(p) == 3) e = 1'b1;
    if (wr && int'(wrn) >= NR)     e = 1'b1;
    if (iss && int'(iss_rn) >= NR) e = 1'b1;
    return e;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NR; i++) begin
      m_rf[i]   = '0;
      m_busy[i] = 1'b0;
    end
    m_sticky = 1'b0;
  endtask

  task automatic model_edge();
    logic e = exp_exc();
    if (wr && int'(wrn) < NR) begin
      m_rf[wrn]   = wrd;
      m_busy[wrn] = 1'b0;
    end
    if (wr0) begin
      m_rf[0]   = r0d;
      m_busy[0] = 1'b0;
    end
    if (iss && int'(iss_rn) < NR) m_busy[iss_rn] = 1'b1;
    if (e)           m_sticky = 1'b1;
    else if (ex_clr) m_sticky = 1'b0;
  endtask

  task automatic check_all();
    for (int p = 0; p < NP; p++) begin
      check_val($sformatf("rd%0d", p), rd[p*DW +: DW], exp_rd(p));
      check_val($sformatf("busy%0d", p), DW'(busy[p]), DW'(exp_busy(p)));
    end
    check_val("exception", DW'(exception), DW'(exp_exc()));
    check_val("rd0", rd0, wr0 ? r0d : m_rf[0]);
    check_val("ex_sticky", DW'(ex_sticky), DW'(m_sticky));
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle();
    rn = '0; reg_forward = '0;
    wr = 1'b0; wrn = '0; wrd = '0;
    wr0 = 1'b0; r0d = '0;
    iss = 1'b0; iss_rn = '0; ex_clr = 1'b0;
  endtask

  task automatic set_port(input int p, input int n, input int f);
    rn[p*NW +: NW]          = NW'(n);
    reg_forward[p*FW +: FW] = FW'(f);
  endtask

  // Inputs are applied just after a falling edge; outputs are checked
  // before the rising edge, the model advances with the edge.
  task automatic cycle();
    #2;
    check_all();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    idle();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    rst_n = 1'b1;

    // Bypass: same-cycle write visible before and after the edge.
    idle();
    wr = 1'b1; wrn = 4'd5; wrd = 32'hBEEF; set_port(0, 5, 0);
    #1 check_val("bypass_pre", rd[0 +: DW], 32'hBEEF);
    cycle();
    idle(); set_port(0, 5, 0);
    #1 check_val("bypass_post", rd[0 +: DW], 32'hBEEF);
    cycle();

    // Write collision on R0: R0 port wins.
    idle();
    wr = 1'b1; wrn = 4'd0; wrd = 32'h1111; wr0 = 1'b1; r0d = 32'h2222;
    set_port(1, 0, 0);
    #1 check_val("coll_rd0", rd0, 32'h2222);
    cycle();
    idle(); set_port(1, 0, 0);
    #1 check_val("coll_r0", rd[DW +: DW], 32'h2222);
    cycle();

    // Scoreboard: issue, writeback clears, simultaneous issue+write stays busy.
    idle(); iss = 1'b1; iss_rn = 4'd7; cycle();
    idle(); set_port(2, 7, 0);
    #1 check_val("sb_set", DW'(busy[2]), 1);
    cycle();
    idle(); set_port(2, 7, 0); wr = 1'b1; wrn = 4'd7; wrd = 32'h77;
    #1 check_val("sb_wb_unblock", DW'(busy[2]), 0);
    cycle();
    idle(); iss = 1'b1; iss_rn = 4'd7; wr = 1'b1; wrn = 4'd7; wrd = 32'h78; cycle();
    idle(); set_port(2, 7, 0);
    #1 check_val("sb_set_wins", DW'(busy[2]), 1);
    cycle();

    // Range error on write, then reserved code, then sticky clear.
    idle(); wr = 1'b1; wrn = 4'd13; wrd = 32'hDEAD;
    #1 check_val("range_exc", DW'(exception), 1);
    cycle();
    idle();
    #1 check_val("range_sticky", DW'(ex_sticky), 1);
    cycle();
    idle(); set_port(1, 3, 3);
    #1 check_val("rsvd_rd", rd[DW +: DW], 0);
    check_val("rsvd_exc", DW'(exception), 1);
    cycle();
    idle(); ex_clr = 1'b1; cycle();
    idle();
    #1 check_val("sticky_clr", DW'(ex_sticky), 0);
    cycle();

    // Asynchronous reset between edges with state present.
    idle(); wr = 1'b1; wrn = 4'd3; wrd = 32'h1234; iss = 1'b1; iss_rn = 4'd14; cycle();
    idle(); iss = 1'b1; iss_rn = 4'd3; cycle();
    idle(); set_port(0, 3, 0); set_port(1, 7, 0);
    #1 check_all();
    #1 rst_n = 1'b0;
    model_reset();
    #1 check_val("rst_r3", rd[0 +: DW], 0);
    check_val("rst_busy", DW'(busy), 0);
    check_val("rst_sticky", DW'(ex_sticky), 0);
    check_all();
    @(negedge clk);
    rst_n = 1'b1;

    // Randomised traffic across all ports.
    for (int c = 0; c < 400; c++) begin
      int r;
      idle();
      for (int p = 0; p < NP; p++) begin
        int n, f;
        n = ($urandom_range(0, 29) == 0) ? int'($urandom_range(NR, 15)) : int'($urandom_range(0, NR-1));
        r = int'($urandom_range(0, 39));
        f = (r < 28) ? 0 : (r < 33) ? 1 : (r < 39) ? 2 : 3;
        set_port(p, n, f);
      end
      wr     = 1'($urandom_range(0, 1));
      wrn    = ($urandom_range(0, 29) == 0) ? NW'($urandom_range(NR, 15)) : NW'($urandom_range(0, NR-1));
      wrd    = $urandom;
      wr0    = ($urandom_range(0, 4) == 0);
      r0d    = $urandom;
      iss    = 1'($urandom_range(0, 1));
      iss_rn = ($urandom_range(0, 29) == 0) ? NW'($urandom_range(NR, 15)) : NW'($urandom_range(0, NR-1));
      ex_clr = ($urandom_range(0, 2) == 0);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
